// File: rtl/ifetch_bridge.sv
// Instruction fetch bridge: turns one 32-bit CPU fetch into two 16-bit program
// memory reads, with alignment/size checking and a per-halfword timeout.
module ifetch_bridge #(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [63:0]       iadr_i,
    input  logic [1:0]        isiz_i,
    output logic              iack_o,
    output logic [31:0]       idat_o,
    output logic              ierr_o,
    output logic [ADDR_W-2:0] madr_o,
    output logic              mstb_o,
    input  logic [15:0]       mdat_i,
    input  logic              mack_i
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        ACK,
        ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-3:0] a_q, a_d;
    logic [15:0]       lo_q, lo_d;
    logic [15:0]       hi_q, hi_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Address bits beyond the memory window are deliberately ignored.
    logic unused_iadr;
    assign unused_iadr = ^iadr_i[63:ADDR_W];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (isiz_i == 2'b10 && iadr_i[1:0] == 2'b00) begin
                    a_d     = iadr_i[ADDR_W-1:2];
                    state_d = LO;
                end else if (isiz_i != 2'b00) begin
                    state_d = ERR;
                end
            end
            LO: begin
                // An acknowledge on the last allowed cycle still wins over the timeout.
                if (mack_i) begin
                    lo_d    = mdat_i;
                    cnt_d   = '0;
                    state_d = HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HI: begin
                if (mack_i) begin
                    hi_d    = mdat_i;
                    state_d = ACK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset drops the strobe at once.
    always_comb begin
        iack_o = 1'b0;
        ierr_o = 1'b0;
        idat_o = '0;
        mstb_o = 1'b0;
        madr_o = '0;
        case (state_q)
            LO: begin
                mstb_o = 1'b1;
                madr_o = {a_q, 1'b0};
            end
            HI: begin
                mstb_o = 1'b1;
                madr_o = {a_q, 1'b1};
            end
            ACK: begin
                iack_o = 1'b1;
                idat_o = {hi_q, lo_q};
            end
            ERR: begin
                iack_o = 1'b1;
                ierr_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
